// File: rtl/pipe_pkg.sv
// Shared types for the RV32I inter-stage buffers: decode-stage control/data bundles
// and the stage occupancy state.
package pipe_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic [2:0] MemWrite;
        logic [1:0] Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } de_ctrl_t;

    typedef struct packed {
        logic [31:0] RD1;
        logic [31:0] RD2;
        logic [31:0] PC;
        logic [4:0]  Rd;
        logic [31:0] ImmExt;
        logic [31:0] PCPlus4;
        logic [4:0]  Rs1;
        logic [4:0]  Rs2;
    } de_data_t;

    typedef enum logic [1:0] {
        EMPTY,
        MAIN,
        SKID
    } pipe_state_e;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);
    localparam int DE_DATA_W = $bits(de_data_t);

endpackage

// File: rtl/pipe_skid_entry.sv
// Single parked beat with its valid bit; catches the beat accepted while the
// main register of pipe_stage_buf is stalled.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DE_CTRL_W,
    parameter int DATA_W = DE_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over load so a flush can never leave a parked beat behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with flush-to-bubble and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid variant with a registered in_ready_o.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DE_CTRL_W,
    parameter int DATA_W = DE_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              main_vld_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;
    logic              in_xfer;
    logic              out_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign out_xfer = main_vld_q & out_ready_i;
    assign in_xfer  = in_valid_i & in_ready_o & ~flush_i;

`ifdef PIPE_STAGE_SKID_EN
    pipe_state_e       state_q;
    logic              in_ready_q;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_clr;

    assign skid_load = (state_q == MAIN) & in_xfer & ~out_xfer;
    assign skid_clr  = flush_i | ((state_q == SKID) & out_xfer);

    pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (skid_clr),
        .load_i (skid_load),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .vld_o  (skid_vld),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );

    // in_ready_o comes straight from a flop, so out_ready_i never reaches it combinationally.
    assign in_ready_o = in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_q     <= MAIN;
                        main_vld_q  <= 1'b1;
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                    end
                end
                MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                    end else if (in_xfer) begin
                        state_q    <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q     <= EMPTY;
                        main_vld_q  <= 1'b0;
                        main_ctrl_q <= '0;
                    end
                end
                SKID: begin
                    // Parked beat is older than nothing else held, so it is promoted as the next out.
                    if (out_xfer && skid_vld) begin
                        state_q     <= MAIN;
                        in_ready_q  <= 1'b1;
                        main_ctrl_q <= skid_ctrl;
                        main_data_q <= skid_data;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    main_vld_q  <= 1'b0;
                    main_ctrl_q <= '0;
                end
            endcase
        end
    end
`else
    // A held beat that drains this cycle frees the register for a new beat on the same edge.
    assign in_ready_o = out_ready_i | ~main_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (flush_i) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
        end else if (in_xfer) begin
            main_vld_q  <= 1'b1;
            main_ctrl_q <= in_ctrl_i;
            main_data_q <= in_data_i;
        end else if (out_xfer) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
        end
    end
`endif

    assign bubble_d = (~main_vld_q | flush_i) ? sat_inc(bubble_q) : bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign out_valid_o  = main_vld_q;
    assign out_ctrl_o   = main_vld_q ? main_ctrl_q : '0;
    assign out_data_o   = main_data_q;
    assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; the skid or combinational-ready scenario is
// chosen by PIPE_STAGE_SKID_EN, matching the build of the design.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = DE_CTRL_W;
    localparam int DW = DE_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [CW-1:0] in_ctrl_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic          out_ready_i = 1'b0;

    logic          in_ready_o, out_valid_o;
    logic [CW-1:0] out_ctrl_o;
    logic [DW-1:0] out_data_o;
    logic [15:0]   bubble_cnt_o;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_bubble;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    pipe_stage_buf #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data),
        .bubble_cnt_o(s_bubble)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [CW-1:0] c);
        logic [24:0] w;
        w = 25'h1A00000 | 25'(c);
        return {7{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CW-1:0] c);
        in_valid_i = 1'b1;
        in_ctrl_i  = c;
        in_data_i  = mk(c);
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        in_ctrl_i  = '0;
        in_data_i  = '0;
    endtask

    task automatic chk_out(input string tag, input logic [CW-1:0] c);
        chk({tag, "_vld"}, 256'(out_valid_o), 256'(1'b1));
        chk({tag, "_ctrl"}, 256'(out_ctrl_o), 256'(c));
        chk({tag, "_data"}, 256'(out_data_o), 256'(mk(c)));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"}, 256'(out_valid_o), 256'(1'b0));
        chk({tag, "_ctrl"}, 256'(out_ctrl_o), 256'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 256'(out_valid_o), 256'(1'b0));
        chk("rst_ctrl", 256'(out_ctrl_o), 256'(0));
        chk("rst_data", 256'(out_data_o), 256'(0));
        chk("rst_rdy", 256'(in_ready_o), 256'(1'b1));
        chk("rst_bub", 256'(bubble_cnt_o), 256'(0));
        rst_n = 1'b1;

        step();
        chk("bub_s1", 256'(s_bubble), 256'(1));
        step();
        chk("bub_s2", 256'(s_bubble), 256'(2));
        step();
        step();
        step();
        chk("bub_s_sat", 256'(s_bubble), 256'(3));
        chk("bub_5", 256'(bubble_cnt_o), 256'(5));

        out_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(CW'(i));
            step();
            chk_out("stream", CW'(i));
            chk("stream_rdy", 256'(in_ready_o), 256'(1'b1));
        end
        idle();
        step();
        chk_empty("stream_end");
        chk("bub_6", 256'(bubble_cnt_o), 256'(6));

`ifdef PIPE_STAGE_SKID_EN
        out_ready_i = 1'b0;
        send(CW'('h0A));
        step();
        chk_out("bp_a", CW'('h0A));
        chk("bp_rdy_a", 256'(in_ready_o), 256'(1'b1));
        send(CW'('h0B));
        step();
        chk_out("bp_hold_a", CW'('h0A));
        chk("bp_rdy_b", 256'(in_ready_o), 256'(1'b0));
        send(CW'('h0C));
        step();
        chk_out("bp_stall", CW'('h0A));
        chk("bp_rdy_stall", 256'(in_ready_o), 256'(1'b0));
        idle();
        out_ready_i = 1'b1;
        step();
        chk_out("bp_b", CW'('h0B));
        chk("bp_rdy_rise", 256'(in_ready_o), 256'(1'b1));
        step();
        chk_empty("bp_drained");

        out_ready_i = 1'b0;
        send(CW'('h0D));
        step();
        send(CW'('h0E));
        step();
        chk("fl_rdy_skid", 256'(in_ready_o), 256'(1'b0));
        flush_i = 1'b1;
        send(CW'('h0F));
        step();
        flush_i = 1'b0;
        idle();
        out_ready_i = 1'b1;
        chk_empty("fl_next");
        chk("fl_rdy", 256'(in_ready_o), 256'(1'b1));
        step();
        chk_empty("fl_after");
        send(CW'('h10));
        step();
        chk_out("fl_resume", CW'('h10));
        idle();
        step();
        chk_empty("fl_resume_end");
`else
        out_ready_i = 1'b0;
        send(CW'('h11));
        step();
        chk_out("full_h", CW'('h11));
        chk("full_rdy", 256'(in_ready_o), 256'(1'b0));
        send(CW'('h12));
        step();
        chk_out("full_hold", CW'('h11));
        out_ready_i = 1'b1;
        #1;
        chk("pulse_rdy", 256'(in_ready_o), 256'(1'b1));
        step();
        chk_out("replace_j", CW'('h12));
        idle();
        step();
        chk_empty("replace_end");

        out_ready_i = 1'b0;
        send(CW'('h13));
        step();
        chk_out("fl_k", CW'('h13));
        flush_i = 1'b1;
        send(CW'('h14));
        step();
        flush_i = 1'b0;
        idle();
        chk_empty("fl_next");
        chk("fl_rdy", 256'(in_ready_o), 256'(1'b1));
        out_ready_i = 1'b1;
        step();
        chk_empty("fl_after");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, handshaked pipeline stage buffer that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RV32I pipeline. Control and data bundles have independent widths, and each beat carries valid/ready flow control. A synchronous flush inserts a bubble by clearing valid and zeroing control, which lets the hazard unit kill wrong-path instructions. An optional 2-entry skid buffer registers the upstream ready path, so a stall never propagates combinationally across the stage.

## Interface
- CTRL_W, default 13, width of the control bundle; zeroed on flush and reset
- DATA_W, default 175, width of the data bundle (operands, PC, imm, rd, rs1, rs2); never zeroed on flush
- CNT_W, default 16, width of the bubble counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous kill of all held beats
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept a beat
- in_ctrl_i  in  CTRL_W  upstream control bundle
- in_data_i  in  DATA_W  upstream data bundle
- out_valid_o  out  1  downstream beat valid
- out_ready_i  in  1  downstream accepts
- out_ctrl_o  out  CTRL_W  control; forced to 0 whenever out_valid_o=0
- out_data_o  out  DATA_W  data; don't-care when out_valid_o=0
- bubble_cnt_o  out  CNT_W  saturating count of bubble cycles

## Operation
- Transfer in: in_valid_i & in_ready_o & !flush_i.
- Transfer out: out_valid_o & out_ready_i.
- Beats leave in arrival order. No beat is duplicated or dropped, except on flush.
- Flush has the highest priority:
  - Next cycle: all valid bits are 0, held control is 0, the skid entry is empty.
  - A beat presented in the flush cycle is discarded.
- Bubble counter:
  - Increments each cycle in which out_valid_o=0 or flush_i=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Reset, asynchronous:
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, bubble_cnt_o=0.
  - in_ready_o=1.
  - Skid entry is empty.

## Timing
- Latency: 1 cycle from in transfer to out_valid_o when the stage is empty.
- Throughput: 1 beat/cycle while out_ready_i=1.
- With skid, the state machine has three states:
  - EMPTY, main register empty:
    - In transfer → MAIN.
  - MAIN, main register valid:
    - In transfer and out transfer → MAIN.
    - In transfer without out transfer → SKID (beat parked in the skid entry).
    - Out transfer only → EMPTY.
  - SKID, both entries valid:
    - in_ready_o=0.
    - Out transfer → MAIN, with the skid beat promoted to the main register.
  - Flush from any state → EMPTY.
- With skid, in_ready_o is a flop output equal to (state != SKID). It has no combinational path from out_ready_i.
- Without skid, in_ready_o = out_ready_i | !out_valid_o, which is combinational.
- If rst_n deasserts mid-beat, nothing is retained. The first accept is possible on the first rising edge after release.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined: 2-entry skid buffer, registered in_ready_o, states EMPTY/MAIN/SKID as described in Timing.
- Undefined:
  - Single register with combinational in_ready_o; the SKID state does not exist.
  - Functional order and flush behaviour are unchanged.
  - The stage accepts a new beat in the same cycle the held beat drains.

## Structure
- Package pipe_pkg:
  - Typedef de_ctrl_t, packed struct: RegWrite 1, ResultSrc 2, MemWrite 3, Jump 2, Branch 1, ALUControl 3, ALUSrc 1 (13 bits total).
  - Typedef de_data_t, packed struct: RD1 32, RD2 32, PC 32, Rd 5, ImmExt 32, PCPlus4 32, Rs1 5, Rs2 5 (175 bits total).
  - State enum pipe_state_e {EMPTY, MAIN, SKID}.
  - Localparams DE_CTRL_W and DE_DATA_W.
- Sub-module pipe_skid_entry: the single parked register with its valid bit. It is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset with rst_n=0 for 2 cycles, inputs idle → out_valid_o=0, out_ctrl_o=0, in_ready_o=1, bubble_cnt_o=0.
- Streaming: out_ready_i=1, beats ctrl 0x001..0x004 on 4 consecutive cycles → each appears 1 cycle later, in order, one per cycle.
- Backpressure (skid): out_ready_i=0, send beats A and B → in_ready_o drops the cycle after B is accepted. Release out_ready_i → A then B emerge on consecutive cycles, and in_ready_o rises after A leaves.
- Flush from SKID with in_valid_i=1 on the same cycle → next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; the flushed-cycle beat never appears.
- Bubble counter with CNT_W=2: 5 idle cycles → bubble_cnt_o saturates at 3.
- Build without PIPE_STAGE_SKID_EN, hold the stage full with out_ready_i=0, then pulse out_ready_i=1 with in_valid_i=1 → in_ready_o=1 in the same cycle and the new beat replaces the old one with no gap.
